pic_prog_loader: RTL and testbench
==================================

# pic_prog_loader

Byte-stream program loader that fills the PIC instruction memory through its write port (`wdata`/`we`), which the CPU core itself never drives. It accepts a framed byte stream over a valid/ready handshake, assembles 12-bit instruction words, and writes them to consecutive instruction addresses. It verifies a checksum, then releases the CPU from reset. It sits beside `cpu`: its `instr_*` outputs drive `instr_mem`, and `cpu_rst` drives the core reset.

## Interface
- `PIC_INSTR_WIDTH`, 12, instruction word width; fixed at 12 by the frame format.
- `L2_PIC_INSTR_MEM_DEPTH`, 9, log2 of instruction memory depth in words.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `byte_i`  in  8  stream data.
- `byte_valid`  in  1  `byte_i` is valid.
- `byte_ready`  out  1  loader accepts `byte_i` this cycle.
- `instr_addr`  out  L2_PIC_INSTR_MEM_DEPTH  write address to `instr_mem`.
- `instr_wdata`  out  PIC_INSTR_WIDTH  write data to `instr_mem`.
- `instr_we`  out  1  write strobe, one cycle per word.
- `cpu_rst`  out  1  hold CPU in reset while high.
- `done`  out  1  load completed successfully (level).
- `error`  out  1  load aborted (level).

## Operation
- **Byte transfer:** a byte is accepted on a cycle where `byte_valid && byte_ready`.
- **Frame format:**
  - header byte 0xA5
  - count high byte
  - count low byte; N = 16-bit word count
  - N word pairs, each hi byte then lo byte; hi byte carries bits [11:8] in its low nibble, and its upper nibble must be 0
  - checksum byte
- **Checksum:** XOR of every byte after the header and before the checksum byte. The frame is good when the received checksum equals that XOR.
- **States:**
  - IDLE: `byte_ready`=0. `start` → HDR and clears the checksum accumulator and address counter.
  - HDR: byte == 0xA5 → CNT_H; else → ERR.
  - CNT_H → CNT_L.
  - CNT_L: N == 0 or N > 2^L2_PIC_INSTR_MEM_DEPTH → ERR; else → W_HI.
  - W_HI: upper nibble != 0 → ERR; else latch bits [11:8] → W_LO.
  - W_LO: form the word; issue a write at the current address; increment the address. If this was word N → CHK; else → W_HI.
  - CHK: match → DONE; mismatch → ERR.
  - DONE: `done`=1, `cpu_rst`=0, `byte_ready`=0. `start` → HDR.
  - ERR: `error`=1, `cpu_rst`=1, `byte_ready`=0. `start` → HDR.
- **Readiness and reset hold:** `byte_ready`=1 in HDR through CHK. `cpu_rst`=1 in every state except DONE.
- **`start` handling:** ignored in HDR through CHK. In DONE or ERR it clears `done`/`error` the next cycle.
- **Counters:** the address counter is L2_PIC_INSTR_MEM_DEPTH bits and starts at 0. It never wraps within a legal frame, because N ≤ depth. A 16-bit remaining-word counter decrements per word.
- **Rejected bytes:** the byte that triggers ERR is consumed. The loader never back-pressures mid-frame.
- **Partial writes:** words already written before an error are not undone. `cpu_rst` stays high.

## Timing
- **Reset values** (applied the cycle after `rst` is sampled high):
  - state = IDLE
  - `byte_ready`=0, `instr_we`=0, `instr_addr`=0, `instr_wdata`=0
  - `done`=0, `error`=0, `cpu_rst`=1
- **Reset priority:** `rst` mid-load aborts immediately with the same values; no write is issued after it. `rst` wins over `start` in the same cycle.
- **State and handshake:** all outputs are registered. `byte_ready` reflects the current state, so the cycle after `start` has `byte_ready`=1.
- **Write timing:**
  - `instr_we` pulses high for exactly the one cycle after a W_LO byte is accepted.
  - `instr_addr`/`instr_wdata` are valid in that same cycle.
  - The address increments so that the next write uses +1.
- **Status timing:** `done` and the `cpu_rst` fall occur the cycle after the checksum byte is accepted. That is at least one cycle after the last `instr_we`, so the final write completes while the CPU is still held.
- **Throughput:** one byte per cycle with `byte_valid` held high. A frame of N words takes 2N+4 accepted bytes.
- **Idle bus:** `byte_valid` low stalls the FSM with no state change.

## Test plan
- **Reset:** reset → `cpu_rst`=1, `done`=0, `error`=0, `byte_ready`=0. Bytes offered in IDLE are not accepted.
- **Good 3-word frame:** `start`, then A5 00 03 / 0A 25 / 00 01 / 08 FF / checksum.
  - Checksum = 00^03^0A^25^00^01^08^FF.
  - Required writes, one `instr_we` pulse each: addr 0←0xA25, addr 1←0x001, addr 2←0x8FF.
  - Then `done`=1 and `cpu_rst`=0 the cycle after the checksum byte.
- **Stall:** same frame with `byte_valid` toggled randomly → identical writes and result.
- **Bad header:** 0x5A → `error`=1 and no `instr_we`. Bad count: N=0, and separately N=513 at depth 9 → ERR.
- **Bad checksum:** a good frame with the checksum XOR 0x01 → all 3 writes occur, then `error`=1 and `cpu_rst` stays 1. Separately, a hi byte of 0x1A → ERR at that byte.
- **Restart mid-load:** `rst` after the first word → outputs return to reset values and no further writes. A later `start` plus a good frame → `done`=1. Also `start` in DONE → `done` clears and `cpu_rst` reasserts.

Source files
------------

// File: rtl/pic_prog_loader.sv
// pic_prog_loader
//
// Fills the PIC instruction memory from a framed byte stream and then lets the
// CPU out of reset. Frame: 0xA5, count hi, count lo, N x (hi, lo) word pairs,
// XOR checksum over every byte between the header and the checksum itself.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   byte_i        : stream byte
//   byte_valid    : byte_i is valid
//   byte_ready    : loader accepts byte_i this cycle (HDR through CHK)
//   instr_addr    : instruction memory write address
//   instr_wdata   : instruction memory write data
//   instr_we      : one-cycle write strobe per assembled word
//   cpu_rst       : holds the CPU in reset while high (low only in DONE)
//   done, error   : level status of the last load
module pic_prog_loader #(
    parameter int PIC_INSTR_WIDTH        = 12,
    parameter int L2_PIC_INSTR_MEM_DEPTH = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [7:0]                        byte_i,
    input  logic                              byte_valid,
    output logic                              byte_ready,
    output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] instr_addr,
    output logic [PIC_INSTR_WIDTH-1:0]        instr_wdata,
    output logic                              instr_we,
    output logic                              cpu_rst,
    output logic                              done,
    output logic                              error
);

    localparam int AW = L2_PIC_INSTR_MEM_DEPTH;
    localparam logic [16:0]   MEM_DEPTH = 17'(1 << AW);
    localparam logic [AW-1:0] ADDR_ONE  = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_CNT_H,
        S_CNT_L,
        S_W_HI,
        S_W_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_hi_q, cnt_hi_d;
    logic [15:0]                rem_q, rem_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [3:0]                 hi_q, hi_d;
    logic [7:0]                 csum_q, csum_d;

    logic                       byte_ready_q, byte_ready_d;
    logic                       instr_we_q, instr_we_d;
    logic [AW-1:0]              instr_addr_q, instr_addr_d;
    logic [PIC_INSTR_WIDTH-1:0] instr_wdata_q, instr_wdata_d;
    logic                       cpu_rst_q, cpu_rst_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    logic                       accept;
    logic [15:0]                n_word;

    // byte_ready_q already encodes "state is HDR..CHK", so it doubles as the
    // acceptance qualifier.
    assign accept = byte_valid && byte_ready_q;
    assign n_word = {cnt_hi_q, byte_i};

    always_comb begin
        state_d       = state_q;
        cnt_hi_d      = cnt_hi_q;
        rem_d         = rem_q;
        addr_d        = addr_q;
        hi_d          = hi_q;
        csum_d        = csum_q;
        instr_we_d    = 1'b0;
        instr_addr_d  = instr_addr_q;
        instr_wdata_d = instr_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    csum_d  = 8'h00;
                    addr_d  = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_d = (byte_i == 8'hA5) ? S_CNT_H : S_ERR;
                end
            end
            S_CNT_H: begin
                if (accept) begin
                    cnt_hi_d = byte_i;
                    csum_d   = csum_q ^ byte_i;
                    state_d  = S_CNT_L;
                end
            end
            S_CNT_L: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_i;
                    rem_d  = n_word;
                    if (n_word == 16'd0 || {1'b0, n_word} > MEM_DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_W_HI;
                    end
                end
            end
            S_W_HI: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_i;
                    if (byte_i[7:4] != 4'h0) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = byte_i[3:0];
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (accept) begin
                    csum_d        = csum_q ^ byte_i;
                    instr_we_d    = 1'b1;
                    instr_addr_d  = addr_q;
                    instr_wdata_d = {hi_q, byte_i};
                    addr_d        = addr_q + ADDR_ONE;
                    rem_d         = rem_q - 16'd1;
                    state_d       = (rem_q == 16'd1) ? S_CHK : S_W_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (byte_i == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state so they line
        // up with state_q on the following cycle.
        byte_ready_d = (state_d == S_HDR)  || (state_d == S_CNT_H) ||
                       (state_d == S_CNT_L) || (state_d == S_W_HI) ||
                       (state_d == S_W_LO)  || (state_d == S_CHK);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        cpu_rst_d    = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        // Frame bookkeeping is re-initialised on start, so it needs no reset.
        cnt_hi_q <= cnt_hi_d;
        rem_q    <= rem_d;
        hi_q     <= hi_d;
        csum_q   <= csum_d;
        addr_q   <= addr_d;
        if (rst) begin
            state_q       <= S_IDLE;
            byte_ready_q  <= 1'b0;
            instr_we_q    <= 1'b0;
            instr_addr_q  <= '0;
            instr_wdata_q <= '0;
            cpu_rst_q     <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_ready_q  <= byte_ready_d;
            instr_we_q    <= instr_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_wdata_q <= instr_wdata_d;
            cpu_rst_q     <= cpu_rst_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign instr_we    = instr_we_q;
    assign instr_addr  = instr_addr_q;
    assign instr_wdata = instr_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_pic_prog_loader.sv
module tb_pic_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [8:0]  instr_addr;
    logic [11:0] instr_wdata;
    logic        instr_we;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    // expected writes: {addr[8:0], data[11:0]}
    logic [20:0] exp_wr[$];
    // expected status on a done/error rising edge: {cpu_rst, error, done}
    logic [2:0]  exp_st[$];

    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    localparam logic [2:0] ST_DONE = 3'b001;
    localparam logic [2:0] ST_ERR  = 3'b110;

    pic_prog_loader #(
        .PIC_INSTR_WIDTH(12),
        .L2_PIC_INSTR_MEM_DEPTH(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .byte_i(byte_i),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .instr_addr(instr_addr),
        .instr_wdata(instr_wdata),
        .instr_we(instr_we),
        .cpu_rst(cpu_rst),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or changes status.
    always @(negedge clk) begin
        if (instr_we) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr %0h data %0h expected none",
                         instr_addr, instr_wdata);
            end else begin
                logic [20:0] e;
                e = exp_wr.pop_front();
                if ({instr_addr, instr_wdata} !== e) begin
                    bad++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             instr_addr, instr_wdata, e[20:12], e[11:0]);
                end
            end
            chk("cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
        end
        if ((done && !prev_done) || (error && !prev_err)) begin
            total++;
            if (exp_st.size() == 0) begin
                bad++;
                $display("FAIL status_unexpected: got %b expected none", {cpu_rst, error, done});
            end else begin
                logic [2:0] s;
                s = exp_st.pop_front();
                if ({cpu_rst, error, done} !== s) begin
                    bad++;
                    $display("FAIL status: got %b expected %b", {cpu_rst, error, done}, s);
                end
            end
        end
        prev_done <= done;
        prev_err  <= error;
    end

    // All stimulus tasks are entered and left at a negedge.
    task automatic send(input logic [7:0] b, input bit rnd);
        int n;
        int guard;
        n = rnd ? int'($urandom_range(0, 3)) : 0;
        repeat (n) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_i     = b;
        byte_valid = 1'b1;
        guard      = 0;
        while (!byte_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got byte_ready 0 expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[], input bit rnd);
        foreach (bytes[i]) send(bytes[i], rnd);
    endtask

    task automatic push_good_writes();
        exp_wr.push_back({9'd0, 12'hA25});
        exp_wr.push_back({9'd1, 12'h001});
        exp_wr.push_back({9'd2, 12'h8FF});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, instr_we}, 32'd0);
        chk({tag, "_addr"}, {23'd0, instr_addr}, 32'd0);
        chk({tag, "_wdata"}, {20'd0, instr_wdata}, 32'd0);
    endtask

    // checksum 00^03^0A^25^00^01^08^FF = DA
    logic [7:0] good_frame[] = '{8'hA5, 8'h00, 8'h03, 8'h0A, 8'h25,
                                 8'h00, 8'h01, 8'h08, 8'hFF, 8'hDA};
    logic [7:0] badck_frame[] = '{8'hA5, 8'h00, 8'h03, 8'h0A, 8'h25,
                                  8'h00, 8'h01, 8'h08, 8'hFF, 8'hDB};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then offer bytes in IDLE: none may be accepted.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");
        byte_i     = 8'hA5;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", {31'd0, byte_ready}, 32'd0);
        byte_valid = 1'b0;

        // Good 3-word frame, back to back.
        push_good_writes();
        exp_st.push_back(ST_DONE);
        pulse_start();
        chk("ready_after_start", {31'd0, byte_ready}, 32'd1);
        send_frame(good_frame, 1'b0);
        chk("good_done", {31'd0, done}, 32'd1);
        chk("good_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("good_ready_off", {31'd0, byte_ready}, 32'd0);

        // start in DONE clears done and reasserts cpu_rst.
        pulse_start();
        chk("restart_done_clr", {31'd0, done}, 32'd0);
        chk("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("restart_ready", {31'd0, byte_ready}, 32'd1);

        // Same frame with random stalls (already in HDR).
        push_good_writes();
        exp_st.push_back(ST_DONE);
        send_frame(good_frame, 1'b1);
        chk("stall_done", {31'd0, done}, 32'd1);

        // Bad header.
        exp_st.push_back(ST_ERR);
        pulse_start();
        send(8'h5A, 1'b0);
        chk("badhdr_error", {31'd0, error}, 32'd1);
        chk("badhdr_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // N = 0.
        exp_st.push_back(ST_ERR);
        pulse_start();
        chk("start_in_err_clr", {31'd0, error}, 32'd0);
        send_frame('{8'hA5, 8'h00, 8'h00}, 1'b0);
        chk("n0_error", {31'd0, error}, 32'd1);

        // N = 513 exceeds depth 512.
        exp_st.push_back(ST_ERR);
        pulse_start();
        send_frame('{8'hA5, 8'h02, 8'h01}, 1'b0);
        chk("n513_error", {31'd0, error}, 32'd1);

        // Bad checksum: all writes land, then error.
        push_good_writes();
        exp_st.push_back(ST_ERR);
        pulse_start();
        send_frame(badck_frame, 1'b0);
        chk("badck_error", {31'd0, error}, 32'd1);
        chk("badck_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("badck_done", {31'd0, done}, 32'd0);

        // Hi byte with non-zero upper nibble.
        exp_st.push_back(ST_ERR);
        pulse_start();
        send_frame('{8'hA5, 8'h00, 8'h03, 8'h1A}, 1'b0);
        chk("badhi_error", {31'd0, error}, 32'd1);

        // Reset after the first word.
        exp_wr.push_back({9'd0, 12'hA25});
        pulse_start();
        send_frame('{8'hA5, 8'h00, 8'h03, 8'h0A, 8'h25}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrst");
        byte_i     = 8'h00;
        byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        chk("midrst_idle_ready", {31'd0, byte_ready}, 32'd0);

        // Good frame after the aborted one.
        push_good_writes();
        exp_st.push_back(ST_DONE);
        pulse_start();
        send_frame(good_frame, 1'b0);
        chk("recover_done", {31'd0, done}, 32'd1);
        chk("recover_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        repeat (3) @(negedge clk);
        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("st_queue_empty", exp_st.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
